// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, captures imem words into an IR and hands them to
// decode over valid/ready. Optional FETCH_BOUNDS_CHECK_EN turns end-of-program wrap into FAULT.
module fetch_sequencer #(
  parameter logic [31:0] ResetAddr = 32'd0,
  parameter logic [31:0] LastAddr  = 32'd84,
  parameter logic [31:0] Step      = 32'd4
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        start_i,
  input  logic        halt_req_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_addr_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  output logic        ir_valid_o,
  input  logic        ir_ready_i,
  output logic [31:0] ir_instr_o,
  output logic [31:0] ir_pc_o,
  output logic        busy_o,
  output logic        fault_o
);

  typedef enum logic [1:0] {StIdle, StRun, StHalt, StFault} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_instr_q, ir_instr_d;
  logic [31:0] ir_pc_q, ir_pc_d;
  logic        ir_valid_q, ir_valid_d;

  logic [31:0] pc_next;
  logic [31:0] redir_tgt;
  logic        can_capture;

  assign pc_next     = pc_q + Step;
  assign redir_tgt   = redirect_addr_i & ~32'h3;
  assign can_capture = !ir_valid_q || ir_ready_i;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_instr_d = ir_instr_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    // A held word drains on ready in every state; a RUN capture overrides this below.
    if (ir_valid_q && ir_ready_i) begin
      ir_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StRun;
      end
      StRun: begin
        if (redirect_valid_i) begin
          ir_valid_d = 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
          if (redir_tgt > LastAddr) begin
            state_d = StFault;
          end else begin
            pc_d = redir_tgt;
            if (halt_req_i) state_d = StHalt;
          end
`else
          pc_d = (redir_tgt > LastAddr) ? ResetAddr : redir_tgt;
          if (halt_req_i) state_d = StHalt;
`endif
        end else if (halt_req_i) begin
          state_d = StHalt;
        end else if (can_capture) begin
`ifdef FETCH_BOUNDS_CHECK_EN
          if (pc_q > LastAddr) begin
            state_d = StFault;
          end else begin
            ir_instr_d = imem_instr_i;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            pc_d       = pc_next;
          end
`else
          ir_instr_d = imem_instr_i;
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b1;
          // Wrap also when the increment itself overflows 32 bits.
          pc_d = ((pc_next > LastAddr) || (pc_next < pc_q)) ? ResetAddr : pc_next;
`endif
        end
      end
      StHalt: begin
        if (start_i && !halt_req_i) state_d = StRun;
      end
      StFault: begin
        state_d = StFault;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= StIdle;
      pc_q       <= ResetAddr;
      ir_instr_q <= 32'd0;
      ir_pc_q    <= 32'd0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_instr_q <= ir_instr_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign imem_addr_o = pc_q;
  assign ir_valid_o  = ir_valid_q;
  assign ir_instr_o  = ir_instr_q;
  assign ir_pc_o     = ir_pc_q;
  assign busy_o      = (state_q == StRun);
`ifdef FETCH_BOUNDS_CHECK_EN
  assign fault_o     = (state_q == StFault);
`else
  assign fault_o     = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: vector table for the main run, hand sequences for
// stall-redirect, async reset mid-stall and out-of-range redirect.
module tb_fetch_sequencer;

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam bit BoundsEn = 1'b1;
`else
  localparam bit BoundsEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, halt_req, redirect_valid, ir_ready;
  logic [31:0] redirect_addr;
  logic [31:0] imem_addr, imem_instr, ir_instr, ir_pc;
  logic        ir_valid, busy, fault;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  assign imem_instr = mem_word(imem_addr);

  fetch_sequencer dut (
    .clk_i            (clk),
    .reset_ni         (reset_n),
    .start_i          (start),
    .halt_req_i       (halt_req),
    .redirect_valid_i (redirect_valid),
    .redirect_addr_i  (redirect_addr),
    .imem_addr_o      (imem_addr),
    .imem_instr_i     (imem_instr),
    .ir_valid_o       (ir_valid),
    .ir_ready_i       (ir_ready),
    .ir_instr_o       (ir_instr),
    .ir_pc_o          (ir_pc),
    .busy_o           (busy),
    .fault_o          (fault)
  );

  typedef struct {
    logic        st, hr, rv;
    logic [31:0] ra;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic        eb;
    logic [31:0] ea;
    logic        ef;
  } vec_t;

  vec_t vecs[27];

  function automatic vec_t mk(input logic st, hr, rv, input logic [31:0] ra, input logic rdy,
                              input logic ev, input logic [31:0] epc, input logic eb,
                              input logic [31:0] ea, input logic ef);
    vec_t v;
    v.st = st; v.hr = hr; v.rv = rv; v.ra = ra; v.rdy = rdy;
    v.ev = ev; v.epc = epc; v.eb = eb; v.ea = ea; v.ef = ef;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, hr, rv, input logic [31:0] ra, input logic rdy);
    start = st; halt_req = hr; redirect_valid = rv; redirect_addr = ra; ir_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " ir_valid"}, {31'd0, ir_valid}, 32'd0);
    chk({tag, " ir_instr"}, ir_instr, 32'd0);
    chk({tag, " ir_pc"}, ir_pc, 32'd0);
    chk({tag, " imem_addr"}, imem_addr, 32'd0);
    chk({tag, " busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " fault"}, {31'd0, fault}, 32'd0);
  endtask

  initial begin
    // st hr rv ra rdy | ev epc eb ea ef
    vecs[0]  = mk(1, 0, 0, 0, 1,  0, 0,    1, 0,    0);
    vecs[1]  = mk(0, 0, 0, 0, 1,  1, 0,    1, 4,    0);
    vecs[2]  = mk(0, 0, 0, 0, 1,  1, 4,    1, 8,    0);
    vecs[3]  = mk(0, 0, 0, 0, 1,  1, 8,    1, 12,   0);
    vecs[4]  = mk(0, 0, 0, 0, 1,  1, 12,   1, 16,   0);
    vecs[5]  = mk(0, 0, 0, 0, 0,  1, 12,   1, 16,   0);
    vecs[6]  = mk(0, 0, 0, 0, 0,  1, 12,   1, 16,   0);
    vecs[7]  = mk(0, 0, 0, 0, 0,  1, 12,   1, 16,   0);
    vecs[8]  = mk(0, 0, 0, 0, 1,  1, 16,   1, 20,   0);
    vecs[9]  = mk(0, 0, 1, 32'h3A, 1, 0, 0, 1, 32'h38, 0);
    vecs[10] = mk(0, 0, 0, 0, 1,  1, 32'h38, 1, 32'h3C, 0);
    vecs[11] = mk(0, 0, 1, 32, 1, 0, 0,    1, 32,   0);
    vecs[12] = mk(0, 0, 0, 0, 1,  1, 32,   1, 36,   0);
    vecs[13] = mk(0, 1, 0, 0, 0,  1, 32,   0, 36,   0);
    vecs[14] = mk(0, 1, 0, 0, 0,  1, 32,   0, 36,   0);
    vecs[15] = mk(1, 1, 0, 0, 1,  0, 0,    0, 36,   0);
    vecs[16] = mk(0, 0, 0, 0, 1,  0, 0,    0, 36,   0);
    vecs[17] = mk(1, 0, 0, 0, 1,  0, 0,    1, 36,   0);
    vecs[18] = mk(0, 0, 0, 0, 1,  1, 36,   1, 40,   0);
    vecs[19] = mk(1, 0, 0, 0, 1,  1, 40,   1, 44,   0);
    vecs[20] = mk(0, 1, 1, 80, 1, 0, 0,    0, 80,   0);
    vecs[21] = mk(1, 0, 0, 0, 1,  0, 0,    1, 80,   0);
    vecs[22] = mk(0, 0, 0, 0, 1,  1, 80,   1, 84,   0);
    vecs[23] = mk(0, 0, 0, 0, 1,  1, 84,   1, BoundsEn ? 32'd88 : 32'd0, 0);
    vecs[24] = BoundsEn ? mk(0, 0, 0, 0, 1, 0, 0, 0, 88, 1) : mk(0, 0, 0, 0, 1, 1, 0, 1, 4, 0);
    vecs[25] = BoundsEn ? mk(1, 0, 0, 0, 1, 0, 0, 0, 88, 1) : mk(1, 0, 0, 0, 1, 1, 4, 1, 8, 0);
    vecs[26] = BoundsEn ? mk(0, 0, 1, 32'h100, 1, 0, 0, 0, 88, 1)
                        : mk(0, 0, 1, 32'h100, 1, 0, 0, 1, 0, 0);

    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    #12;
    chk_reset_vals("reset");
    reset_n = 1'b1;

    for (int i = 0; i < 27; i++) begin
      drive(vecs[i].st, vecs[i].hr, vecs[i].rv, vecs[i].ra, vecs[i].rdy);
      tick();
      chk($sformatf("v%0d ir_valid", i), {31'd0, ir_valid}, {31'd0, vecs[i].ev});
      chk($sformatf("v%0d busy", i), {31'd0, busy}, {31'd0, vecs[i].eb});
      chk($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].ea);
      chk($sformatf("v%0d fault", i), {31'd0, fault}, {31'd0, vecs[i].ef});
      if (vecs[i].ev) begin
        chk($sformatf("v%0d ir_pc", i), ir_pc, vecs[i].epc);
        chk($sformatf("v%0d ir_instr", i), ir_instr, mem_word(vecs[i].epc));
      end
    end

    // Redirect while stalled, then async reset in the middle of a stall.
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    drive(1, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 1); tick();
    chk("seq first pc", ir_pc, 32'd0);
    drive(0, 0, 0, 0, 0); tick();
    chk("seq stall valid", {31'd0, ir_valid}, 32'd1);
    chk("seq stall addr", imem_addr, 32'd4);
    drive(0, 0, 1, 32'h11, 0); tick();
    chk("stalled redirect valid", {31'd0, ir_valid}, 32'd0);
    chk("stalled redirect addr", imem_addr, 32'h10);
    drive(0, 0, 0, 0, 0); tick();
    chk("redirect target pc", ir_pc, 32'h10);
    chk("redirect target instr", ir_instr, mem_word(32'h10));
    drive(0, 0, 0, 0, 0); tick();
    chk("held pc", ir_pc, 32'h10);
    chk("held addr", imem_addr, 32'h14);
    #3;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("async reset");
    #2;
    reset_n = 1'b1;

    // Out-of-range redirect: fault when bounds-checked, wrap to reset address otherwise.
    drive(1, 0, 0, 0, 1); tick();
    drive(0, 0, 1, 32'h100, 1); tick();
    chk("oor redirect fault", {31'd0, fault}, {31'd0, BoundsEn});
    chk("oor redirect busy", {31'd0, busy}, {31'd0, !BoundsEn});
    chk("oor redirect valid", {31'd0, ir_valid}, 32'd0);
    if (!BoundsEn) chk("oor redirect addr", imem_addr, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that owns the program counter and sequences the combinational instruction memory. It drives the word-aligned byte address, captures the returned word into an instruction register, and hands it to decode over a valid/ready handshake. It also handles start, halt, branch/jump redirects and the end-of-program boundary. It sits between the instruction memory and the decode/control stage of the single-cycle core.

## Interface

- RESET_ADDR, 32'd0, first fetch address after reset and after wrap.
- LAST_ADDR, 32'd84, highest valid instruction address (inclusive).
- STEP, 4, PC increment in bytes.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; leaves IDLE and begins fetching.
- halt_req  in  1  level; stops fetch after the current cycle.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_addr  in  32  redirect target (byte address).
- imem_addr  out  32  address to instruction memory (combinational from PC).
- imem_instr  in  32  instruction word returned combinationally.
- ir_valid  out  1  ir_instr/ir_pc hold an unconsumed instruction.
- ir_ready  in  1  decode accepts the instruction this cycle.
- ir_instr  out  32  registered instruction word.
- ir_pc  out  32  address the instruction was fetched from.
- busy  out  1  high in RUN.
- fault  out  1  sticky out-of-range fetch flag.

## Operation

- States: IDLE, RUN, HALT, FAULT. Reset enters IDLE.
- IDLE: no capture. `start` moves to RUN next edge. PC holds RESET_ADDR.
- RUN:
  - Capture condition: `!ir_valid || ir_ready`.
  - On capture: ir_instr<=imem_instr, ir_pc<=pc, ir_valid<=1, pc<=pc+STEP.
  - If ir_valid && ir_ready and no capture occurs, ir_valid<=0.
  - Stall: ir_valid && !ir_ready holds pc, ir_instr, ir_pc and ir_valid unchanged.
- Redirect (RUN only, highest priority): pc<={redirect_addr[31:2],2'b00}, ir_valid<=0 (the in-flight word is flushed), no capture that cycle. The redirect is honoured even while stalled.
- halt_req in RUN: next state HALT; no capture that cycle. An already valid IR is kept until consumed. HALT returns to RUN on `start` when halt_req is low. PC is preserved.
- If halt_req and redirect arrive in the same cycle, the redirect updates PC, then the block enters HALT.
- End of program: when pc+STEP > LAST_ADDR, behaviour is set by Configuration.
- Arithmetic: 32-bit unsigned; imem_addr = pc always (also in IDLE/HALT/FAULT).
- FAULT: terminal; only reset exits. ir_valid drains normally via ir_ready; no new captures.

## Timing

- Reset values: pc=RESET_ADDR, imem_addr=RESET_ADDR, ir_valid=0, ir_instr=0, ir_pc=0, busy=0, fault=0, state IDLE.
- The asynchronous reset asserted mid-operation clears everything immediately. Pending handshakes are dropped.
- Fetch latency: the word at address A appears on ir_instr one edge after pc==A with the capture condition true.
- Throughput: 1 instruction/cycle while ir_ready is held high.
- Redirect penalty: the first target word is valid 2 edges after redirect_valid is sampled.
- start is sampled only in IDLE/HALT; it is ignored in RUN and FAULT.

## Configuration

- FETCH_BOUNDS_CHECK_EN defined: a capture at pc==LAST_ADDR completes normally.
  - The next attempted fetch with pc>LAST_ADDR, or any redirect to an address >LAST_ADDR, enters FAULT and sets fault=1. The next PC is not captured.
- Undefined: pc wraps to RESET_ADDR when pc+STEP > LAST_ADDR.
  - Out-of-range redirects are clamped by wrapping: pc<=RESET_ADDR.
  - fault is tied to 0 and the FAULT state is unreachable.

## Test plan

- Reset, start, ir_ready=1 -> ir_pc sequence 0,4,8,…; each ir_instr equals imem contents; ir_valid high every cycle from the second edge after start.
- ir_ready=0 for 3 cycles at ir_pc=12 -> ir_pc/ir_instr held at 12 and pc held at 16; after ready goes high, 16 follows immediately.
- redirect_valid with redirect_addr=0x3A at pc=20 -> ir_valid=0 next cycle; then ir_pc=0x38 (aligned).
- halt_req during RUN at pc=32 -> HALT, busy=0; after halt_req drops and start is pulsed, fetch resumes at 32 with no duplicate or lost word.
- Run past 84 -> macro defined: fault=1, FAULT state, last ir_pc=84. Macro undefined: ir_pc goes 84 then 0.
- reset_n pulsed low mid-stall -> all outputs return to reset values without a clock edge.
